// File: rtl/thread_disposition.sv
`default_nettype none
// ============================================================================
// Module      : thread_disposition
// Description : Executes the disposition word that ends a thread pass.
//               Performs the optional data-memory write, then retires the
//               thread, requeues it immediately, or parks it in a small
//               sleep table until its delay expires and it is requeued.
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               in_*                       - disposition input (valid/ready)
//               mem_wr_*                   - data-memory write port (valid/ready)
//               rq_*                       - work-queue requeue port (valid/ready)
//               retire_valid/_thread_id    - one-cycle retirement pulse
//               retired_count              - retirements since reset (wraps)
//               sleeping                   - sleep-table occupancy bitmap
// Revision    : 1.0 - initial release
// ============================================================================
module thread_disposition #(
    parameter int THREAD_ID_W = 6,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 64,
    parameter int SLEEP_W     = 16,
    parameter int NUM_SLOTS   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [THREAD_ID_W-1:0] in_thread_id,
    input  logic [SLEEP_W-1:0]     in_sleep,
    input  logic [SLEEP_W-1:0]     in_write,
    input  logic [ADDR_W-1:0]      in_write_address,
    input  logic [DATA_W-1:0]      in_write_data,
    output logic                   mem_wr_valid,
    input  logic                   mem_wr_ready,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    output logic                   rq_valid,
    input  logic                   rq_ready,
    output logic [THREAD_ID_W-1:0] rq_thread_id,
    output logic                   retire_valid,
    output logic [THREAD_ID_W-1:0] retire_thread_id,
    output logic [15:0]            retired_count,
    output logic [NUM_SLOTS-1:0]   sleeping
);

    localparam int c_IDX_W = $clog2(NUM_SLOTS);
    // A positive sleep value never needs the sign bit.
    localparam int c_CNT_W = SLEEP_W - 1;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WRITE    = 2'd1;
    localparam logic [1:0] c_ST_DISPATCH = 2'd2;
    localparam logic [1:0] c_ST_REQUEUE  = 2'd3;

    // ------------------------------------------------------------------
    // State and held disposition
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [THREAD_ID_W-1:0] r_tid;
    logic [SLEEP_W-1:0]     r_sleep;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;

    logic                   r_retire_valid;
    logic [THREAD_ID_W-1:0] r_retire_tid;
    logic [15:0]            r_retired_count;

    // Sleep table
    logic [NUM_SLOTS-1:0]   r_slot_valid;
    logic [THREAD_ID_W-1:0] r_slot_tid [NUM_SLOTS];
    logic [c_CNT_W-1:0]     r_slot_cnt [NUM_SLOTS];

    // Requeue-port lock: remembers which source was presented but not yet
    // accepted, so a later-expiring slot cannot swap the request mid-flight.
    logic                   r_lock_valid;
    logic                   r_lock_slot;
    logic [c_IDX_W-1:0]     r_lock_idx;

    logic                   w_accept;
    logic                   w_in_write_pos;
    logic                   w_sleep_neg;
    logic                   w_sleep_zero;
    logic                   w_free_any;
    logic [c_IDX_W-1:0]     w_free_idx;
    logic                   w_exp_any;
    logic [c_IDX_W-1:0]     w_exp_idx;
    logic                   w_src_valid;
    logic                   w_src_slot;
    logic [c_IDX_W-1:0]     w_src_idx;
    logic [THREAD_ID_W-1:0] w_src_tid;
    logic                   w_rq_hs;
    logic                   w_slot_release;
    logic                   w_alloc;
    logic                   w_retire;

    assign in_ready       = (r_state == c_ST_IDLE) && !reset;
    assign w_accept       = in_valid && in_ready;
    assign w_in_write_pos = !in_write[SLEEP_W-1] && (in_write != '0);
    assign w_sleep_neg    = r_sleep[SLEEP_W-1];
    assign w_sleep_zero   = (r_sleep == '0);

    // ------------------------------------------------------------------
    // Lowest-index free slot and lowest-index expired slot
    // ------------------------------------------------------------------
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_exp_any  = 1'b0;
        w_exp_idx  = '0;
        // Descending scan so the lowest index is the last (winning) write.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slot_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
            if (r_slot_valid[i] && (r_slot_cnt[i] == '0)) begin
                w_exp_any = 1'b1;
                w_exp_idx = c_IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Requeue-port source selection: locked source, else expired slot,
    // else the FSM's own requeue.
    // ------------------------------------------------------------------
    always_comb begin
        w_src_valid = 1'b0;
        w_src_slot  = 1'b0;
        w_src_idx   = '0;
        if (r_lock_valid) begin
            w_src_valid = 1'b1;
            w_src_slot  = r_lock_slot;
            w_src_idx   = r_lock_idx;
        end else if (w_exp_any) begin
            w_src_valid = 1'b1;
            w_src_slot  = 1'b1;
            w_src_idx   = w_exp_idx;
        end else if (r_state == c_ST_REQUEUE) begin
            w_src_valid = 1'b1;
        end
    end

    always_comb begin
        w_src_tid = '0;
        if (w_src_valid) begin
            w_src_tid = w_src_slot ? r_slot_tid[w_src_idx] : r_tid;
        end
    end

    assign w_rq_hs        = w_src_valid && rq_ready;
    assign w_slot_release = w_rq_hs && w_src_slot;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_alloc     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_in_write_pos ? c_ST_WRITE : c_ST_DISPATCH;
                end
            end
            c_ST_WRITE: begin
                if (mem_wr_ready) begin
                    w_state_nxt = c_ST_DISPATCH;
                end
            end
            c_ST_DISPATCH: begin
                if (w_sleep_neg) begin
                    w_retire    = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_sleep_zero) begin
                    w_state_nxt = c_ST_REQUEUE;
                end else if (w_free_any) begin
                    w_alloc     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
                // Sleep requested but table full: stall here.
            end
            c_ST_REQUEUE: begin
                if (w_rq_hs && !w_src_slot) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential: FSM, held disposition, retirement, port lock
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_tid           <= '0;
            r_sleep         <= '0;
            r_addr          <= '0;
            r_data          <= '0;
            r_retire_valid  <= 1'b0;
            r_retire_tid    <= '0;
            r_retired_count <= '0;
            r_lock_valid    <= 1'b0;
            r_lock_slot     <= 1'b0;
            r_lock_idx      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_retire_valid <= w_retire;
            if (w_accept) begin
                r_tid   <= in_thread_id;
                r_sleep <= in_sleep;
                r_addr  <= in_write_address;
                r_data  <= in_write_data;
            end
            if (w_retire) begin
                r_retire_tid    <= r_tid;
                r_retired_count <= r_retired_count + 16'd1;
            end
            r_lock_valid <= w_src_valid && !rq_ready;
            r_lock_slot  <= w_src_slot;
            r_lock_idx   <= w_src_idx;
        end
    end

    // ------------------------------------------------------------------
    // Sequential: sleep table
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot_tid[i] <= '0;
                r_slot_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_slot_release && (w_src_idx == c_IDX_W'(i))) begin
                    r_slot_valid[i] <= 1'b0;
                end else if (w_alloc && (w_free_idx == c_IDX_W'(i))) begin
                    r_slot_valid[i] <= 1'b1;
                    r_slot_tid[i]   <= r_tid;
                    r_slot_cnt[i]   <= r_sleep[c_CNT_W-1:0];
                end else if (r_slot_valid[i] && (r_slot_cnt[i] != '0)) begin
                    r_slot_cnt[i] <= r_slot_cnt[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_wr_valid     = (r_state == c_ST_WRITE);
    assign mem_wr_addr      = r_addr;
    assign mem_wr_data      = r_data;
    assign rq_valid         = w_src_valid;
    assign rq_thread_id     = w_src_tid;
    assign retire_valid     = r_retire_valid;
    assign retire_thread_id = r_retire_tid;
    assign retired_count    = r_retired_count;
    assign sleeping         = r_slot_valid;

endmodule
`default_nettype wire

// File: tb/tb_thread_disposition.sv
`default_nettype none
// ============================================================================
// Module      : tb_thread_disposition
// Description : Self-checking bench for thread_disposition: directed
//               scenarios with cycle-exact expectations, then a randomized
//               run compared against an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_disposition;

    localparam int THREAD_ID_W = 6;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 64;
    localparam int SLEEP_W     = 16;
    localparam int NUM_SLOTS   = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [THREAD_ID_W-1:0] in_thread_id;
    logic [SLEEP_W-1:0]     in_sleep;
    logic [SLEEP_W-1:0]     in_write;
    logic [ADDR_W-1:0]      in_write_address;
    logic [DATA_W-1:0]      in_write_data;
    logic                   mem_wr_valid;
    logic                   mem_wr_ready;
    logic [ADDR_W-1:0]      mem_wr_addr;
    logic [DATA_W-1:0]      mem_wr_data;
    logic                   rq_valid;
    logic                   rq_ready;
    logic [THREAD_ID_W-1:0] rq_thread_id;
    logic                   retire_valid;
    logic [THREAD_ID_W-1:0] retire_thread_id;
    logic [15:0]            retired_count;
    logic [NUM_SLOTS-1:0]   sleeping;

    always #5 clk = ~clk;

    thread_disposition #(
        .THREAD_ID_W (THREAD_ID_W),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SLEEP_W     (SLEEP_W),
        .NUM_SLOTS   (NUM_SLOTS)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_thread_id     (in_thread_id),
        .in_sleep         (in_sleep),
        .in_write         (in_write),
        .in_write_address (in_write_address),
        .in_write_data    (in_write_data),
        .mem_wr_valid     (mem_wr_valid),
        .mem_wr_ready     (mem_wr_ready),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .rq_valid         (rq_valid),
        .rq_ready         (rq_ready),
        .rq_thread_id     (rq_thread_id),
        .retire_valid     (retire_valid),
        .retire_thread_id (retire_thread_id),
        .retired_count    (retired_count),
        .sleeping         (sleeping)
    );

    int checks = 0;
    int errors = 0;

    // Observed transactions, sampled mid-cycle.
    logic [79:0] wq[$];
    logic [5:0]  rqq[$];
    logic [5:0]  retq[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wr_valid && mem_wr_ready) wq.push_back({mem_wr_addr, mem_wr_data});
            if (rq_valid && rq_ready)         rqq.push_back(rq_thread_id);
            if (retire_valid)                 retq.push_back(retire_thread_id);
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a disposition, waits (bounded) for in_ready, and returns
    // #1 after the accepting edge.
    task automatic accept(input logic [5:0] tid, input int slp, input int wr,
                          input logic [15:0] a, input logic [63:0] d);
        int n;
        n = 0;
        in_thread_id     = tid;
        in_sleep         = SLEEP_W'(slp);
        in_write         = SLEEP_W'(wr);
        in_write_address = a;
        in_write_data    = d;
        in_valid         = 1'b1;
        while (!in_ready && n < 2000) begin
            tick(1);
            n++;
        end
        check("accept_ready", {79'd0, in_ready}, 80'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait until the block is fully quiet.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(sleeping == '0 && in_ready && !rq_valid) && n < 5000) begin
            tick(1);
            n++;
        end
        check(tag, {79'd0, (n < 5000)}, 80'd1);
    endtask

    logic        rnd_on = 1'b0;
    logic [79:0] exp_wq[$];
    logic [5:0]  exp_ret[$];
    logic [63:0] exp_mask;
    logic [63:0] got_mask;
    int          exp_rq_n;
    int          exp_retired;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic early;
        logic [5:0] order [5];
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_thread_id     = '0;
        in_sleep         = '0;
        in_write         = '0;
        in_write_address = '0;
        in_write_data    = '0;
        mem_wr_ready     = 1'b0;
        rq_ready         = 1'b0;

        // ---------------- Reset state ----------------
        tick(2);
        check("rst_in_ready",      {79'd0, in_ready},      80'd0);
        check("rst_mem_wr_valid",  {79'd0, mem_wr_valid},  80'd0);
        check("rst_rq_valid",      {79'd0, rq_valid},      80'd0);
        check("rst_retire_valid",  {79'd0, retire_valid},  80'd0);
        check("rst_retired_count", {64'd0, retired_count}, 80'd0);
        check("rst_sleeping",      {76'd0, sleeping},      80'd0);
        check("rst_ids",           {mem_wr_addr, rq_thread_id, retire_thread_id, 52'd0}, 80'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {79'd0, in_ready}, 80'd1);

        // ---------------- Write then retire ----------------
        wq.delete();
        accept(6'd3, -100, 100, 16'h0041, 64'h1);
        check("t1_wr_valid", {79'd0, mem_wr_valid}, 80'd1);
        check("t1_wr_addr_data", {mem_wr_addr, mem_wr_data}, {16'h0041, 64'h1});
        mem_wr_ready = 1'b1;
        tick(1);
        check("t1_wr_done", {78'd0, mem_wr_valid, retire_valid}, 80'd0);
        tick(1);
        check("t1_retire", {56'd0, retire_valid, retire_thread_id, retired_count, in_ready, rq_valid},
              {56'd0, 1'b1, 6'd3, 16'd1, 1'b1, 1'b0});
        tick(1);
        check("t1_retire_pulse", {79'd0, retire_valid}, 80'd0);
        check("t1_wr_count", 80'(wq.size()), 80'd1);
        check("t1_wr_seen", wq.size() > 0 ? wq[0] : 80'hx, {16'h0041, 64'h1});

        // ---------------- Immediate requeue ----------------
        rq_ready = 1'b1;
        accept(6'd5, 0, 0, 16'h0, 64'h0);
        check("t2_dispatch", {78'd0, rq_valid, mem_wr_valid}, 80'd0);
        tick(1);
        check("t2_rq", {72'd0, rq_valid, rq_thread_id, mem_wr_valid}, {72'd0, 1'b1, 6'd5, 1'b0});
        tick(1);
        check("t2_rq_done", {78'd0, rq_valid, in_ready}, 80'd1);

        // ---------------- Sleep 10 ----------------
        rq_ready = 1'b0;
        accept(6'd7, 10, 0, 16'h0, 64'h0);
        tick(1);
        check("t3_alloc", {75'd0, sleeping, rq_valid}, {75'd0, 4'b0001, 1'b0});
        early = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            if (rq_valid) early = 1'b1;
        end
        check("t3_not_early", {79'd0, early}, 80'd0);
        tick(1);
        check("t3_expire", {73'd0, rq_valid, rq_thread_id}, {73'd0, 1'b1, 6'd7});
        rq_ready = 1'b1;
        tick(1);
        check("t3_freed", {75'd0, sleeping, rq_valid}, 80'd0);

        // ---------------- Table full stall ----------------
        rqq.delete();
        for (int k = 0; k < 4; k++) accept(6'(10 + k), 200, 0, 16'h0, 64'h0);
        tick(1);
        check("t4_full", {76'd0, sleeping}, {76'd0, 4'b1111});
        accept(6'd20, 5, 0, 16'h0, 64'h0);
        n = 0;
        while (!in_ready && n < 1000) begin
            tick(1);
            n++;
        end
        check("t4_stall_cycles", 80'(n), 80'd195);
        check("t4_realloc", {76'd0, sleeping}, {76'd0, 4'b1111});
        drain("t4_drain");
        order[0] = 6'd10; order[1] = 6'd11; order[2] = 6'd12; order[3] = 6'd13; order[4] = 6'd20;
        check("t4_rq_count", 80'(rqq.size()), 80'd5);
        for (int k = 0; k < 5; k++) check("t4_rq_order", k < rqq.size() ? 80'(rqq[k]) : 80'hx, 80'(order[k]));

        // ---------------- Slot expiry vs FSM requeue ----------------
        rq_ready = 1'b0;
        accept(6'd30, 300, 0, 16'h0, 64'h0);
        accept(6'd31, 2, 0, 16'h0, 64'h0);
        accept(6'd32, 0, 0, 16'h0, 64'h0);
        check("t5_quiet", {79'd0, rq_valid}, 80'd0);
        tick(1);
        check("t5_slot_first", {73'd0, rq_valid, rq_thread_id}, {73'd0, 1'b1, 6'd31});
        tick(3);
        check("t5_slot_held", {72'd0, rq_valid, rq_thread_id, in_ready}, {72'd0, 1'b1, 6'd31, 1'b0});
        rq_ready = 1'b1;
        tick(1);
        check("t5_fsm_next", {73'd0, rq_valid, rq_thread_id}, {73'd0, 1'b1, 6'd32});
        tick(1);
        check("t5_done", {74'd0, rq_valid, in_ready, sleeping}, {74'd0, 1'b0, 1'b1, 4'b0001});

        // ---------------- Reset during stalled write ----------------
        mem_wr_ready = 1'b0;
        accept(6'd40, 0, 1, 16'h1234, 64'hDEAD_BEEF_0000_0001);
        tick(20);
        check("t6_wr_held", {63'd0, mem_wr_valid, mem_wr_addr}, {63'd0, 1'b1, 16'h1234});
        reset = 1'b1;
        tick(1);
        check("t6_rst_outputs", {56'd0, mem_wr_valid, rq_valid, retire_valid, in_ready, retired_count, sleeping},
              80'd0);
        check("t6_rst_addr_data", {mem_wr_addr, mem_wr_data}, 80'd0);
        reset = 1'b0;
        #1;
        check("t6_in_ready", {79'd0, in_ready}, 80'd1);
        tick(1);
        check("t6_dropped", {77'd0, mem_wr_valid, rq_valid, in_ready}, {77'd0, 1'b0, 1'b0, 1'b1});

        // ---------------- Randomized run vs reference model ----------------
        wq.delete(); rqq.delete(); retq.delete();
        exp_mask    = '0;
        exp_rq_n    = 0;
        exp_retired = 0;
        rnd_on      = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    mem_wr_ready = 1'($urandom_range(0, 1));
                    rq_ready     = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int k = 0; k < 40; k++) begin
            int slp, wr, sel;
            logic [15:0] a;
            logic [63:0] d;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      slp = -int'($urandom_range(1, 300));
            else if (sel == 1) slp = 0;
            else               slp = int'($urandom_range(1, 12));
            wr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : -int'($urandom_range(0, 5));
            a  = 16'($urandom);
            d  = {$urandom, $urandom};
            if (wr > 0) exp_wq.push_back({a, d});
            if (slp < 0) begin
                exp_ret.push_back(6'(k));
                exp_retired++;
            end else begin
                exp_mask[k] = 1'b1;
                exp_rq_n++;
            end
            accept(6'(k), slp, wr, a, d);
        end
        drain("rnd_drain");
        rnd_on = 1'b0;
        tick(2);
        mem_wr_ready = 1'b1;
        rq_ready     = 1'b1;

        check("rnd_wr_count", 80'(wq.size()), 80'(exp_wq.size()));
        for (int k = 0; k < exp_wq.size(); k++)
            check("rnd_wr", k < wq.size() ? wq[k] : 80'hx, exp_wq[k]);
        check("rnd_ret_count", 80'(retq.size()), 80'(exp_ret.size()));
        for (int k = 0; k < exp_ret.size(); k++)
            check("rnd_ret", k < retq.size() ? 80'(retq[k]) : 80'hx, 80'(exp_ret[k]));
        check("rnd_retired_count", {64'd0, retired_count}, 80'(exp_retired));
        got_mask = '0;
        foreach (rqq[k]) got_mask[rqq[k]] = 1'b1;
        check("rnd_rq_count", 80'(rqq.size()), 80'(exp_rq_n));
        check("rnd_rq_set", {16'd0, got_mask}, {16'd0, exp_mask});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
